// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared funct3 encodings and response state for the data memory
package rv32_mem_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic {IDLE, RESP} rsp_state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane placement, extraction and extension for one access
module mem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        big_endian,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wlane,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [1:0]  sz;
  logic [1:0]  sh;
  logic [31:0] raw;
  always_comb begin
    sz = funct3[1:0];
    misaligned = (sz == 2'd1 && addr_lo[0]) || (sz[1] && addr_lo != 2'd0);
    // big-endian puts the lowest address in the top lane of the access
    sh = big_endian ? (sz == 2'd0 ? 2'd3 - addr_lo : sz == 2'd1 ? 2'd2 - addr_lo : 2'd0) : addr_lo;
    byte_en = (sz == 2'd0 ? 4'b0001 : sz == 2'd1 ? 4'b0011 : 4'b1111) << sh;
    wlane = wdata << {sh, 3'b000};
    raw = rword >> {sh, 3'b000};
    rdata = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]} :
            funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
            funct3 == F3_BU ? {24'd0, raw[7:0]} :
            funct3 == F3_HU ? {16'd0, raw[15:0]} : raw;
  end
endmodule

// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressed RV32 data memory with handshakes and fault detection
module byte_data_memory
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter bit BIG_ENDIAN  = 1'b0,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WE,
  input  logic [2:0]           FUNCT3,
  input  logic [31:0]          ADDRESS,
  input  logic [31:0]          WRITE_DATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [31:0]          READ_DATA,
  output logic                 RSP_ERR,
  output logic [ERR_CNT_W-1:0] ERR_COUNT
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  logic [31:0] mem [WORDS];
  logic [IW-1:0] widx;
  logic [3:0] byte_en;
  logic [31:0] wlane, rdata;
  logic misaligned, legal, oor, err, accept;
  rsp_state_e state, state_nx;
  mem_lane_align u_align (
    .funct3     (FUNCT3),
    .addr_lo    (ADDRESS[1:0]),
    .big_endian (BIG_ENDIAN),
    .wdata      (WRITE_DATA),
    .rword      (mem[widx]),
    .byte_en    (byte_en),
    .wlane      (wlane),
    .rdata      (rdata),
    .misaligned (misaligned)
  );
  assign widx = ADDRESS[IW+1:2];
  assign legal = REQ_WE ? FUNCT3 inside {F3_B, F3_H, F3_W} : FUNCT3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign oor = ADDRESS >= 32'(DEPTH_BYTES);
  assign err = !legal || misaligned || oor;
  // reset gates acceptance so the unreset memory cannot be written while RST_N is low
  assign REQ_READY = RST_N && (!RSP_VALID || RSP_READY);
  assign accept = REQ_VALID && REQ_READY;
  always_ff @(posedge CLK)
    if (accept && REQ_WE && !err)
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = accept ? RESP : RSP_READY ? IDLE : state;
  end
  always_comb begin
    RSP_VALID = state == RESP;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      READ_DATA <= '0;
      RSP_ERR   <= 1'b0;
      ERR_COUNT <= '0;
    end else if (accept) begin
      READ_DATA <= (REQ_WE || err) ? '0 : rdata;
      RSP_ERR   <= err;
      if (err && !(&ERR_COUNT)) ERR_COUNT <= ERR_COUNT + 1'b1;
    end
endmodule

// File: tb/tb_byte_data_memory.sv
// tb_byte_data_memory: randomized and directed checks of both endian builds against a byte-array model
module tb_byte_data_memory;
  localparam int DEPTH = 4096;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [2:0] funct3 = 3'd0;
  logic [31:0] address = '0, write_data = '0;
  logic le_req_ready, le_rsp_valid, le_rsp_err, be_req_ready, be_rsp_valid, be_rsp_err;
  logic [31:0] le_read_data, be_read_data;
  logic [15:0] le_err_count, be_err_count;
  logic [7:0] mm [2][128];
  logic [15:0] exp_errs = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  byte_data_memory #(.DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b0), .ERR_CNT_W(16)) u_le (
    .CLK(clk), .RST_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(le_req_ready), .REQ_WE(req_we),
    .FUNCT3(funct3), .ADDRESS(address), .WRITE_DATA(write_data), .RSP_VALID(le_rsp_valid),
    .RSP_READY(rsp_ready), .READ_DATA(le_read_data), .RSP_ERR(le_rsp_err), .ERR_COUNT(le_err_count));
  byte_data_memory #(.DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b1), .ERR_CNT_W(16)) u_be (
    .CLK(clk), .RST_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(be_req_ready), .REQ_WE(req_we),
    .FUNCT3(funct3), .ADDRESS(address), .WRITE_DATA(write_data), .RSP_VALID(be_rsp_valid),
    .RSP_READY(rsp_ready), .READ_DATA(be_read_data), .RSP_ERR(be_rsp_err), .ERR_COUNT(be_err_count));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int nbytes(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || (a % nbytes(f3) != 0) || a >= DEPTH;
  endfunction
  function automatic void model_store(input int e, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = nbytes(f3);
    for (int i = 0; i < n; i++) mm[e][int'(a) + i] = 8'(d >> (8 * (e != 0 ? n - 1 - i : i)));
  endfunction
  function automatic logic [31:0] model_load(input int e, input logic [31:0] a, input logic [2:0] f3);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++) v |= 32'(mm[e][int'(a) + i]) << (8 * (e != 0 ? n - 1 - i : i));
    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r_le, output logic [31:0] r_be);
    logic f;
    logic [31:0] x_le, x_be;
    f = fault(we, f3, a);
    x_le = (we || f) ? 32'd0 : model_load(0, a, f3);
    x_be = (we || f) ? 32'd0 : model_load(1, a, f3);
    req_valid = 1'b1; req_we = we; funct3 = f3; address = a; write_data = d; rsp_ready = 1'b1;
    #1;
    check("req_ready", {le_req_ready, be_req_ready}, 2'b11);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (f && exp_errs != 16'hFFFF) exp_errs++;
    if (we && !f) begin
      model_store(0, a, f3, d);
      model_store(1, a, f3, d);
    end
    check("rsp_valid", {le_rsp_valid, be_rsp_valid}, 2'b11);
    check("rsp_err", {le_rsp_err, be_rsp_err}, {f, f});
    check("rdata_le", le_read_data, x_le);
    check("rdata_be", be_read_data, x_be);
    check("err_count", {le_err_count, be_err_count}, {exp_errs, exp_errs});
    r_le = le_read_data;
    r_be = be_read_data;
  endtask
  initial begin
    logic [31:0] rl, rb, hold_le, hold_be, x_le, x_be, a;
    int r;
    #1;
    check("reset_valid", {le_rsp_valid, be_rsp_valid}, 2'b00);
    check("reset_rdata", le_read_data | be_read_data, 32'd0);
    check("reset_errcnt", {le_err_count, be_err_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_req_ready", {le_req_ready, be_req_ready}, 2'b11);
    for (int w = 0; w < 32; w++) do_req(1'b1, 3'd2, 32'(4 * w), 32'd0, rl, rb);
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, rl, rb);
    do_req(1'b0, 3'd2, 32'h10, 32'd0, rl, rb);
    check("lw_le", rl, 32'h11223344);
    check("lw_be", rb, 32'h11223344);
    do_req(1'b0, 3'd4, 32'h10, 32'd0, rl, rb);
    check("lbu10_le", rl, 32'h44);
    check("lbu10_be", rb, 32'h11);
    do_req(1'b0, 3'd4, 32'h13, 32'd0, rl, rb);
    check("lbu13_le", rl, 32'h11);
    do_req(1'b0, 3'd5, 32'h12, 32'd0, rl, rb);
    check("lhu12_be", rb, 32'h3344);
    do_req(1'b1, 3'd0, 32'h21, 32'h80, rl, rb);
    do_req(1'b0, 3'd0, 32'h21, 32'd0, rl, rb);
    check("lb21", rl, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h21, 32'd0, rl, rb);
    check("lbu21", rl, 32'h80);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, rl, rb);
    check("lw20_le", rl, 32'h00008000);
    do_req(1'b0, 3'd2, 32'h22, 32'd0, rl, rb);
    do_req(1'b1, 3'd1, 32'h5, 32'hBEEF, rl, rb);
    do_req(1'b0, 3'd2, DEPTH, 32'd0, rl, rb);
    do_req(1'b0, 3'd3, 32'h0, 32'd0, rl, rb);
    check("fault_count", le_err_count, 32'd4);
    do_req(1'b0, 3'd2, 32'h4, 32'd0, rl, rb);
    check("fault_nowrite", rl, 32'd0);
    do_req(1'b1, 3'd2, 32'h40, 32'hA5A5_1234, rl, rb);
    do_req(1'b1, 3'd2, 32'h44, 32'h5A5A_9876, rl, rb);
    do_req(1'b0, 3'd2, 32'h40, 32'd0, rl, rb);
    hold_le = le_read_data;
    hold_be = be_read_data;
    x_le = model_load(0, 32'h44, 3'd2);
    x_be = model_load(1, 32'h44, 3'd2);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; address = 32'h44; rsp_ready = 1'b0;
    #1;
    check("stall_req_ready", {le_req_ready, be_req_ready}, 2'b00);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_req_ready", {le_req_ready, be_req_ready}, 2'b00);
      check("stall_valid", {le_rsp_valid, be_rsp_valid}, 2'b11);
      check("stall_rdata_le", le_read_data, hold_le);
      check("stall_rdata_be", be_read_data, hold_be);
    end
    rsp_ready = 1'b1;
    #1;
    check("unstall_req_ready", {le_req_ready, be_req_ready}, 2'b11);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("after_stall_le", le_read_data, x_le);
    check("after_stall_be", be_read_data, x_be);
    @(posedge clk);
    #1;
    check("drain_valid", {le_rsp_valid, be_rsp_valid}, 2'b00);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = r == 0 ? ($urandom | 32'h8000_0000) : r == 1 ? 32'(DEPTH + $urandom_range(0, 7)) : 32'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rl, rb);
    end
    do_req(1'b1, 3'd2, 32'h50, 32'hCAFEBABE, rl, rb);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_drop", {le_rsp_valid, be_rsp_valid}, 2'b00);
    exp_errs = '0;
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; address = 32'h50; write_data = 32'hDEAD0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    check("reset_no_accept", {le_rsp_valid, be_rsp_valid}, 2'b00);
    check("reset_errcnt2", {le_err_count, be_err_count}, 32'd0);
    do_req(1'b0, 3'd2, 32'h50, 32'd0, rl, rb);
    check("post_reset_lw", rl, 32'hCAFEBABE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
